// File: rtl/dc_adpcm_multi_if.sv
// Handshake bundle for dc_adpcm_multi: input word stream and decoded output stream.
// slave = decoder side, master = the stimulus/upstream+downstream side.
interface dc_adpcm_multi_if #(
    parameter int unsigned CH = 2,
    parameter int unsigned SW = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_raw;
    logic [CH*SW-1:0]  din;
    logic              out_valid;
    logic              out_ready;
    logic [CH*SW-1:0]  dout;
    logic              out_err;

    modport slave (
        input  in_valid, in_raw, din, out_ready,
        output in_ready, out_valid, dout, out_err
    );

    modport master (
        output in_valid, in_raw, din, out_ready,
        input  in_ready, out_valid, dout, out_err
    );
endinterface

// File: rtl/dc_adpcm_multi.sv
// N-channel ADPCM-style decoder: raw key words load predictors, delta words update them with saturation.
// Optional macro ADPCM_ADAPT_EN adds a per-channel adaptive step index (0..3).
module dc_adpcm_multi #(
    parameter int unsigned CH      = 2,
    parameter int unsigned SW      = 8,
    parameter int unsigned DW      = 4,
    parameter int unsigned STEP    = 32,
    parameter int unsigned MAX_RUN = 16
) (
    input  logic             clk,
    input  logic             rst,
    dc_adpcm_multi_if.slave  bus
);
    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam int unsigned MW = SW + DW;
    localparam logic [DW-2:0] MAG_MAX = '1;

    typedef enum logic {WAIT_KEY, RUN} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic             out_valid_q, out_valid_d;
    logic [CH*SW-1:0] dout_q, dout_d;
    logic [CH*SW-1:0] dec;
    logic             accept;
    logic             err;

    logic [SW-1:0]    step  [CH];
    logic [DW-1:0]    code  [CH];
    logic [MW-1:0]    mag_x [CH];
    logic [MW:0]      p_n   [CH];

`ifdef ADPCM_ADAPT_EN
    logic [1:0]       k_q [CH];
    logic [1:0]       k_d [CH];
    logic [SW+2:0]    s_sh [CH];

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            s_sh[c] = (SW+3)'(STEP) << k_q[c];
            step[c] = (s_sh[c] > (SW+3)'({SW{1'b1}})) ? '1 : s_sh[c][SW-1:0];
        end
    end
`else
    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            step[c] = SW'(STEP);
        end
    end
`endif

    // The output register doubles as the predictor: both always hold the same value.
    always_comb begin
        dec = dout_q;
        for (int unsigned c = 0; c < CH; c++) begin
            code[c]  = bus.din[c*DW +: DW];
            mag_x[c] = MW'(code[c][DW-2:0]) * MW'(step[c]);
            if (code[c][DW-1])
                p_n[c] = {1'b0, MW'(dout_q[c*SW +: SW])} + {1'b0, mag_x[c]};
            else
                p_n[c] = {1'b0, MW'(dout_q[c*SW +: SW])} - {1'b0, mag_x[c]};
            // Top bit set means the subtraction went below zero.
            if (p_n[c][MW])
                dec[c*SW +: SW] = '0;
            else if (p_n[c][MW-1:SW] != '0)
                dec[c*SW +: SW] = '1;
            else
                dec[c*SW +: SW] = p_n[c][SW-1:0];
        end
    end

    assign bus.in_ready  = ~out_valid_q | bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_err   = err & ~rst;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        err         = 1'b0;
`ifdef ADPCM_ADAPT_EN
        k_d         = k_q;
`endif
        accept      = bus.in_valid & bus.in_ready;
        if (accept) begin
            if (bus.in_raw) begin
                dout_d      = bus.din;
                out_valid_d = 1'b1;
                run_d       = '0;
                state_d     = RUN;
`ifdef ADPCM_ADAPT_EN
                for (int unsigned c = 0; c < CH; c++) k_d[c] = '0;
`endif
            end else begin
                case (state_q)
                    WAIT_KEY: err = 1'b1;
                    RUN: begin
                        if (run_q == RW'(MAX_RUN)) begin
                            err     = 1'b1;
                            state_d = WAIT_KEY;
                        end else begin
                            dout_d      = dec;
                            out_valid_d = 1'b1;
                            run_d       = run_q + 1'b1;
`ifdef ADPCM_ADAPT_EN
                            for (int unsigned c = 0; c < CH; c++) begin
                                if (code[c][DW-2:0] == MAG_MAX && k_q[c] != 2'd3)
                                    k_d[c] = k_q[c] + 2'd1;
                                else if (code[c][DW-2:0] == '0 && k_q[c] != 2'd0)
                                    k_d[c] = k_q[c] - 2'd1;
                            end
`endif
                        end
                    end
                    default: state_d = WAIT_KEY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_KEY;
            run_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
`ifdef ADPCM_ADAPT_EN
            for (int unsigned c = 0; c < CH; c++) k_q[c] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
`ifdef ADPCM_ADAPT_EN
            for (int unsigned c = 0; c < CH; c++) k_q[c] <= k_d[c];
`endif
        end
    end
endmodule

// File: tb/tb_dc_adpcm_multi.sv
// Self-checking bench for dc_adpcm_multi (CH=2, SW=8, DW=4, STEP=32, MAX_RUN=4).
// Honors ADPCM_ADAPT_EN in its reference model when defined.
module tb_dc_adpcm_multi;
    localparam int CH      = 2;
    localparam int SW      = 8;
    localparam int DW      = 4;
    localparam int STEP    = 32;
    localparam int MAX_RUN = 4;
    localparam int PMAX    = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dc_adpcm_multi_if #(.CH(CH), .SW(SW)) bus ();

    dc_adpcm_multi #(
        .CH(CH), .SW(SW), .DW(DW), .STEP(STEP), .MAX_RUN(MAX_RUN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain integers per channel.
    bit m_valid;
    bit m_key;
    int m_run;
    int m_p [CH];
    int m_k [CH];
    bit last_err;

    typedef struct {
        bit          raw;
        logic [15:0] din;
        logic [15:0] exp_dout;
        bit          exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int step_of(input int k);
`ifdef ADPCM_ADAPT_EN
        int s;
        s = STEP << k;
        return (s > PMAX) ? PMAX : s;
`else
        return STEP + 0 * k;
`endif
    endfunction

    function automatic logic [31:0] model_dout();
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r = r | (32'(m_p[c]) << (c * SW));
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_key   = 1'b0;
        m_run   = 0;
        for (int c = 0; c < CH; c++) begin
            m_p[c] = 0;
            m_k[c] = 0;
        end
    endtask

    // One clock: drive, check against the model mid-cycle, then advance the model at the edge.
    task automatic cycle(input bit v, input bit raw, input logic [15:0] d, input bit ordy);
        bit exp_ready, acc, exp_err;
        int dv, code, mag, st, p;
        bus.in_valid  = v;
        bus.in_raw    = raw;
        bus.din       = d;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_ready = !m_valid || ordy;
        acc       = v && exp_ready && !rst;
        exp_err   = acc && !raw && (!m_key || m_run == MAX_RUN);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("out_err", 32'(bus.out_err), 32'(exp_err));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("dout", 32'(bus.dout), model_dout());
        last_err = bus.out_err;
        @(posedge clk);
        dv = int'(d);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (acc) begin
                if (raw) begin
                    for (int c = 0; c < CH; c++) begin
                        m_p[c] = (dv >> (c * SW)) & PMAX;
                        m_k[c] = 0;
                    end
                    m_key   = 1'b1;
                    m_run   = 0;
                    m_valid = 1'b1;
                end else if (exp_err) begin
                    m_key = 1'b0;
                end else begin
                    for (int c = 0; c < CH; c++) begin
                        code = (dv >> (c * DW)) & 15;
                        mag  = code & 7;
                        st   = step_of(m_k[c]);
                        p    = (code >= 8) ? m_p[c] + mag * st : m_p[c] - mag * st;
                        m_p[c] = (p < 0) ? 0 : (p > PMAX) ? PMAX : p;
`ifdef ADPCM_ADAPT_EN
                        if (mag == 7 && m_k[c] < 3) m_k[c]++;
                        else if (mag == 0 && m_k[c] > 0) m_k[c]--;
`endif
                    end
                    m_run++;
                    m_valid = 1'b1;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [15:0] last_exp;
        bit rv, rraw, rrdy;
        logic [15:0] rd;

`ifdef ADPCM_ADAPT_EN
        last_exp = 16'hA0A0;
`else
        last_exp = 16'hC0C0;
`endif
        vecs[0]  = '{1'b0, 16'h0011, 16'h0000, 1'b1};
        vecs[1]  = '{1'b1, 16'h1234, 16'h1234, 1'b0};
        vecs[2]  = '{1'b1, 16'h8040, 16'h8040, 1'b0};
        vecs[3]  = '{1'b0, 16'h002B, 16'h40A0, 1'b0};
        vecs[4]  = '{1'b1, 16'hF0F0, 16'hF0F0, 1'b0};
        vecs[5]  = '{1'b0, 16'h007F, 16'h10FF, 1'b0};
        vecs[6]  = '{1'b1, 16'h0505, 16'h0505, 1'b0};
        vecs[7]  = '{1'b0, 16'h00FF, 16'hE5E5, 1'b0};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'h00FF, 16'hE0E0, 1'b0};
        vecs[10] = '{1'b0, 16'h00FF, 16'hFFFF, 1'b0};
        vecs[11] = '{1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 16'h00FF, 16'hE0E0, 1'b0};
        vecs[13] = '{1'b0, 16'h0011, last_exp, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_raw    = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        last_err      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'd0);
        chk("reset_out_err", 32'(bus.out_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, vecs[i].raw, vecs[i].din, 1'b1);
            chk($sformatf("tbl%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(!vecs[i].exp_err));
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Backpressure: output held for 10 cycles, next word lands one cycle after release.
        cycle(1'b1, 1'b1, 16'h00AA, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 16'h0011, 1'b0);
            chk("hold_dout", 32'(bus.dout), 32'h00AA);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        cycle(1'b1, 1'b1, 16'h0011, 1'b1);
        chk("release_dout", 32'(bus.dout), 32'h0011);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Delta-run limit: four +32 steps decode, the fifth and sixth are rejected.
        cycle(1'b1, 1'b1, 16'h0000, 1'b1);
        for (int i = 1; i <= MAX_RUN; i++) begin
            cycle(1'b1, 1'b0, 16'h0099, 1'b1);
            chk("run_dout", 32'(bus.dout), 32'(32 * i * 257));
            chk("run_err", 32'(last_err), 32'd0);
        end
        cycle(1'b1, 1'b0, 16'h0099, 1'b1);
        chk("run_limit_err", 32'(last_err), 32'd1);
        chk("run_limit_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 1'b0, 16'h0099, 1'b1);
        chk("after_limit_err", 32'(last_err), 32'd1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset with a word in flight: nothing emerges and the key is required again.
        cycle(1'b1, 1'b1, 16'h5A5A, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 16'h7777, 1'b1);
        rst = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        cycle(1'b1, 1'b0, 16'h0011, 1'b1);
        chk("rst_waitkey_err", 32'(last_err), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rraw = ($urandom_range(0, 5) == 0);
            rrdy = ($urandom_range(0, 3) != 0);
            rd   = 16'($urandom);
            rst  = ($urandom_range(0, 199) == 0);
            cycle(rv, rraw, rd, rrdy);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
